// File: rtl/spi_master.sv
// spi_master: mode-0 SPI initiator (CPOL=0, CPHA=0, active-low ssel),
// MSB first unless SPI_MASTER_LSB_FIRST_EN is defined (LSB first both ways).
// Ports: clk, rst (sync, active high); tx_data/tx_valid/tx_last/tx_ready
// byte stream in; rx_data/rx_valid received byte strobe; busy while a
// frame is in progress; sclk/mosi/miso/ssel SPI pins.
module spi_master #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso,
  output logic       ssel
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    NEXT,
    HOLD,
    GAP
  } state_e;

  localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD - 1);

  state_e     state_q, state_d;
  logic       ssel_q, ssel_d;
  logic       sclk_q, sclk_d;
  logic       mosi_q, mosi_d;
  logic       last_q, last_d;
  logic [7:0] tx_sh_q, tx_sh_d;
  logic [7:0] rx_sh_q, rx_sh_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic [7:0] div_cnt_q, div_cnt_d;
  logic [3:0] edge_cnt_q, edge_cnt_d;
  logic [7:0] cnt_q, cnt_d;

  logic       accept;
  logic       tx_first;
  logic       tx_next_bit;
  logic [7:0] tx_shifted;
  logic [7:0] rx_shifted;

  // Bit-order selection: tx_first is the first wire bit of a new byte,
  // tx_next_bit is the bit presented after the current one.
`ifdef SPI_MASTER_LSB_FIRST_EN
  assign tx_first    = tx_data[0];
  assign tx_next_bit = tx_sh_q[1];
  assign tx_shifted  = {1'b0, tx_sh_q[7:1]};
  assign rx_shifted  = {miso, rx_sh_q[7:1]};
`else
  assign tx_first    = tx_data[7];
  assign tx_next_bit = tx_sh_q[6];
  assign tx_shifted  = {tx_sh_q[6:0], 1'b0};
  assign rx_shifted  = {rx_sh_q[6:0], miso};
`endif

  assign tx_ready = ((state_q == IDLE) || (state_q == NEXT)) && !rst;
  assign accept   = tx_valid && tx_ready;
  assign busy     = (state_q != IDLE);
  assign sclk     = sclk_q;
  assign mosi     = mosi_q;
  assign ssel     = ssel_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

  always_comb begin
    state_d    = state_q;
    ssel_d     = ssel_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    last_d     = last_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    div_cnt_d  = div_cnt_q;
    edge_cnt_d = edge_cnt_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          tx_sh_d = tx_data;
          last_d  = tx_last;
          ssel_d  = 1'b0;
          mosi_d  = tx_first;
          cnt_d   = 8'd0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d      = 8'd0;
          div_cnt_d  = 8'd0;
          edge_cnt_d = 4'd0;
          state_d    = SHIFT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      SHIFT: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d  = 8'd0;
          sclk_d     = !sclk_q;
          edge_cnt_d = edge_cnt_q + 4'd1;
          if (!sclk_q) begin
            rx_sh_d = rx_shifted;
          end else if (edge_cnt_q != 4'd15) begin
            tx_sh_d = tx_shifted;
            mosi_d  = tx_next_bit;
          end else begin
            // 16th toggle: byte complete, edge_cnt wraps to 0
            rx_data_d  = rx_sh_q;
            rx_valid_d = 1'b1;
            cnt_d      = 8'd0;
            state_d    = last_q ? HOLD : NEXT;
          end
        end else begin
          div_cnt_d = div_cnt_q + 8'd1;
        end
      end
      NEXT: begin
        if (accept) begin
          tx_sh_d    = tx_data;
          last_d     = tx_last;
          mosi_d     = tx_first;
          div_cnt_d  = 8'd0;
          edge_cnt_d = 4'd0;
          state_d    = SHIFT;
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          ssel_d  = 1'b1;
          mosi_d  = 1'b0;
          cnt_d   = 8'd0;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      GAP: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = 8'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ssel_q     <= 1'b1;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      last_q     <= 1'b0;
      tx_sh_q    <= 8'h00;
      rx_sh_q    <= 8'h00;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      div_cnt_q  <= 8'd0;
      edge_cnt_q <= 4'd0;
      cnt_q      <= 8'd0;
    end else begin
      state_q    <= state_d;
      ssel_q     <= ssel_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      last_q     <= last_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      div_cnt_q  <= div_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed bench for spi_master with a behavioural
// mode-0 slave on the pins and a negedge monitor of the outputs.
module tb_spi_master;

  localparam int CLK_DIV  = 4;
  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;

  // W_xx: byte the slave assembles (MSB first) when DUT sends 0xxx.
  // R_xx: byte the DUT reports when the slave sends 0xxx on the wire.
`ifdef SPI_MASTER_LSB_FIRST_EN
  localparam logic [7:0] W_12 = 8'h48;
  localparam logic [7:0] W_34 = 8'h2C;
  localparam logic [7:0] W_01 = 8'h80;
  localparam logic [7:0] R_01 = 8'h80;
  localparam logic [7:0] R_02 = 8'h40;
  localparam logic [7:0] R_80 = 8'h01;
  localparam logic       FIRST_01 = 1'b1;
`else
  localparam logic [7:0] W_12 = 8'h12;
  localparam logic [7:0] W_34 = 8'h34;
  localparam logic [7:0] W_01 = 8'h01;
  localparam logic [7:0] R_01 = 8'h01;
  localparam logic [7:0] R_02 = 8'h02;
  localparam logic [7:0] R_80 = 8'h80;
  localparam logic       FIRST_01 = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_last = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       sclk;
  logic       mosi;
  logic       miso = 1'b0;
  logic       ssel;

  int pass_n = 0;
  int total_n = 0;

  spi_master #(
    .CLK_DIV (CLK_DIV),
    .CS_SETUP(CS_SETUP),
    .CS_HOLD (CS_HOLD)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_last (tx_last),
    .tx_ready(tx_ready),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .busy    (busy),
    .sclk    (sclk),
    .mosi    (mosi),
    .miso    (miso),
    .ssel    (ssel)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: cumulative counters, tests diff against snapshots
  logic [7:0] rx_log [0:63];
  int rx_n = 0;
  int sclk_rise_n = 0;
  int ssel_rise_n = 0;
  int ssel_low_n = 0;
  int high_run = 0;
  int last_high_run = 0;
  int ssel_rise_cyc = 0;
  int busy_fall_cyc = 0;
  logic m_sclk = 1'b0;
  logic m_ssel = 1'b1;
  logic m_busy = 1'b0;

  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      rx_log[rx_n[5:0]] = rx_data;
      rx_n++;
    end
    if (m_sclk === 1'b0 && sclk === 1'b1) sclk_rise_n++;
    if (m_ssel === 1'b0 && ssel === 1'b1) begin
      ssel_rise_n++;
      ssel_rise_cyc = cyc;
    end
    if (m_busy === 1'b1 && busy === 1'b0) busy_fall_cyc = cyc;
    if (ssel === 1'b0) begin
      ssel_low_n++;
      if (m_ssel === 1'b1) last_high_run = high_run;
      high_run = 0;
    end else begin
      high_run++;
    end
    m_sclk = sclk;
    m_ssel = ssel;
    m_busy = busy;
  end

  // Slave: shifts out slave_bytes MSB first, changes miso after
  // falling sclk, captures mosi on rising sclk.
  logic [7:0] slave_bytes [0:1];
  logic [7:0] mosi_cap [0:1];
  logic       first_mosi = 1'b0;
  logic [7:0] s_sh = 8'h00;
  logic [7:0] s_msh = 8'h00;
  int         s_rises = 0;
  int         s_idx = 0;
  logic       s_ssel = 1'b1;
  logic       s_sclk = 1'b0;

  always @(ssel, sclk) begin
    if (ssel !== s_ssel) begin
      s_rises = 0;
      s_idx = 0;
      if (ssel === 1'b0) begin
        s_sh = slave_bytes[0];
        s_idx = 1;
        mosi_cap[0] = 8'h00;
        mosi_cap[1] = 8'h00;
      end else begin
        s_sh = 8'h00;
      end
      miso = s_sh[7];
    end else if (ssel === 1'b0 && sclk === 1'b1 && s_sclk === 1'b0) begin
      s_msh = {s_msh[6:0], mosi};
      s_rises++;
      if (s_rises == 1) first_mosi = mosi;
      if (s_rises == 8) mosi_cap[0] = s_msh;
      if (s_rises == 16) mosi_cap[1] = s_msh;
    end else if (ssel === 1'b0 && sclk === 1'b0 && s_sclk === 1'b1) begin
      if (s_rises % 8 == 0) begin
        s_sh = (s_idx == 1) ? slave_bytes[1] : 8'h00;
        s_idx++;
      end else begin
        s_sh = {s_sh[6:0], 1'b0};
      end
      miso = s_sh[7];
    end
    s_ssel = ssel;
    s_sclk = sclk;
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic send(input logic [7:0] d, input logic l, output logic ok);
    ok = 1'b0;
    tx_data = d;
    tx_last = l;
    tx_valid = 1'b1;
    for (int i = 0; i < 2000 && !ok; i++) begin
      if (tx_ready === 1'b1) ok = 1'b1;
      step();
    end
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 5000 && !ok; i++) begin
      if (busy === 1'b0) ok = 1'b1;
      else step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tx_valid = 1'b1;
    repeat (3) step();
    total_n++; if (ssel !== 1'b1) $display("FAIL rst_ssel got=%b exp=1", ssel); else pass_n++;
    total_n++; if (sclk !== 1'b0) $display("FAIL rst_sclk got=%b exp=0", sclk); else pass_n++;
    total_n++; if (mosi !== 1'b0) $display("FAIL rst_mosi got=%b exp=0", mosi); else pass_n++;
    total_n++; if (rx_data !== 8'h00) $display("FAIL rst_rx_data got=%h exp=00", rx_data); else pass_n++;
    total_n++; if (rx_valid !== 1'b0) $display("FAIL rst_rx_valid got=%b exp=0", rx_valid); else pass_n++;
    total_n++; if (busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", busy); else pass_n++;
    total_n++; if (tx_ready !== 1'b0) $display("FAIL rst_tx_ready got=%b exp=0", tx_ready); else pass_n++;
    tx_valid = 1'b0;
    rst = 1'b0;
    step();
    total_n++; if (tx_ready !== 1'b1) $display("FAIL idle_tx_ready got=%b exp=1", tx_ready); else pass_n++;
    total_n++; if (busy !== 1'b0) $display("FAIL idle_busy got=%b exp=0", busy); else pass_n++;
  endtask

  task automatic test_single();
    logic ok;
    int b_rx, b_low, b_sclk;
    slave_bytes[0] = 8'h3C;
    slave_bytes[1] = 8'h00;
    b_rx = rx_n; b_low = ssel_low_n; b_sclk = sclk_rise_n;
    send(8'hA5, 1'b1, ok);
    total_n++; if (ok !== 1'b1) $display("FAIL single_accept got=%b exp=1", ok); else pass_n++;
    wait_idle(ok);
    total_n++; if (ok !== 1'b1) $display("FAIL single_done got=%b exp=1", ok); else pass_n++;
    total_n++; if (rx_n - b_rx != 1) $display("FAIL single_rx_pulses got=%0d exp=1", rx_n - b_rx); else pass_n++;
    total_n++; if (rx_log[b_rx[5:0]] !== 8'h3C) $display("FAIL single_rx got=%h exp=3c", rx_log[b_rx[5:0]]); else pass_n++;
    total_n++; if (rx_data !== 8'h3C) $display("FAIL single_rx_data got=%h exp=3c", rx_data); else pass_n++;
    total_n++; if (mosi_cap[0] !== 8'hA5) $display("FAIL single_mosi got=%h exp=a5", mosi_cap[0]); else pass_n++;
    // CS_SETUP + 16*CLK_DIV + CS_HOLD = 2 + 64 + 2
    total_n++; if (ssel_low_n - b_low != 68) $display("FAIL single_ssel_low got=%0d exp=68", ssel_low_n - b_low); else pass_n++;
    total_n++; if (sclk_rise_n - b_sclk != 8) $display("FAIL single_sclk_rises got=%0d exp=8", sclk_rise_n - b_sclk); else pass_n++;
    total_n++; if (busy_fall_cyc - ssel_rise_cyc != 2) $display("FAIL single_busy_tail got=%0d exp=2", busy_fall_cyc - ssel_rise_cyc); else pass_n++;
  endtask

  task automatic test_two_byte();
    logic ok1, ok2, ok3;
    int b_rx, b_sclk, b_rise;
    slave_bytes[0] = 8'h01;
    slave_bytes[1] = 8'h02;
    b_rx = rx_n; b_sclk = sclk_rise_n; b_rise = ssel_rise_n;
    send(8'h12, 1'b0, ok1);
    send(8'h34, 1'b1, ok2);
    wait_idle(ok3);
    total_n++; if ((ok1 & ok2 & ok3) !== 1'b1) $display("FAIL two_flow got=%b%b%b exp=111", ok1, ok2, ok3); else pass_n++;
    total_n++; if (rx_n - b_rx != 2) $display("FAIL two_rx_pulses got=%0d exp=2", rx_n - b_rx); else pass_n++;
    total_n++; if (rx_log[b_rx[5:0]] !== R_01) $display("FAIL two_rx0 got=%h exp=%h", rx_log[b_rx[5:0]], R_01); else pass_n++;
    total_n++; if (rx_log[6'(b_rx + 1)] !== R_02) $display("FAIL two_rx1 got=%h exp=%h", rx_log[6'(b_rx + 1)], R_02); else pass_n++;
    total_n++; if (mosi_cap[0] !== W_12) $display("FAIL two_mosi0 got=%h exp=%h", mosi_cap[0], W_12); else pass_n++;
    total_n++; if (mosi_cap[1] !== W_34) $display("FAIL two_mosi1 got=%h exp=%h", mosi_cap[1], W_34); else pass_n++;
    total_n++; if (sclk_rise_n - b_sclk != 16) $display("FAIL two_sclk_rises got=%0d exp=16", sclk_rise_n - b_sclk); else pass_n++;
    total_n++; if (ssel_rise_n - b_rise != 1) $display("FAIL two_ssel_rises got=%0d exp=1", ssel_rise_n - b_rise); else pass_n++;
  endtask

  task automatic test_backpressure();
    logic ok;
    logic seen;
    int b_rx;
    int bad_sclk, bad_ssel, bad_ready;
    slave_bytes[0] = 8'hC3;
    slave_bytes[1] = 8'h5A;
    b_rx = rx_n;
    bad_sclk = 0; bad_ssel = 0; bad_ready = 0;
    send(8'h12, 1'b0, ok);
    seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      if (rx_n > b_rx) seen = 1'b1;
      else step();
    end
    total_n++; if (seen !== 1'b1) $display("FAIL bp_first_byte got=%b exp=1", seen); else pass_n++;
    for (int i = 0; i < 50; i++) begin
      if (sclk !== 1'b0) bad_sclk++;
      if (ssel !== 1'b0) bad_ssel++;
      if (tx_ready !== 1'b1) bad_ready++;
      step();
    end
    total_n++; if (bad_sclk != 0) $display("FAIL bp_sclk_idle got=%0d exp=0", bad_sclk); else pass_n++;
    total_n++; if (bad_ssel != 0) $display("FAIL bp_ssel_low got=%0d exp=0", bad_ssel); else pass_n++;
    total_n++; if (bad_ready != 0) $display("FAIL bp_tx_ready got=%0d exp=0", bad_ready); else pass_n++;
    send(8'h34, 1'b1, ok);
    wait_idle(ok);
    total_n++; if (ok !== 1'b1) $display("FAIL bp_done got=%b exp=1", ok); else pass_n++;
    total_n++; if (rx_n - b_rx != 2) $display("FAIL bp_rx_pulses got=%0d exp=2", rx_n - b_rx); else pass_n++;
    total_n++; if (rx_log[6'(b_rx + 1)] !== 8'h5A) $display("FAIL bp_rx1 got=%h exp=5a", rx_log[6'(b_rx + 1)]); else pass_n++;
    total_n++; if (mosi_cap[1] !== W_34) $display("FAIL bp_mosi1 got=%h exp=%h", mosi_cap[1], W_34); else pass_n++;
  endtask

  task automatic test_reset_mid();
    logic ok;
    logic seen;
    int b_rx, b_sclk;
    slave_bytes[0] = 8'h00;
    slave_bytes[1] = 8'h00;
    b_rx = rx_n; b_sclk = sclk_rise_n;
    send(8'hFF, 1'b1, ok);
    seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      if (sclk_rise_n - b_sclk >= 5) seen = 1'b1;
      else step();
    end
    total_n++; if (seen !== 1'b1) $display("FAIL rmid_reach got=%b exp=1", seen); else pass_n++;
    rst = 1'b1;
    @(posedge clk);
    #1;
    total_n++; if (ssel !== 1'b1) $display("FAIL rmid_ssel got=%b exp=1", ssel); else pass_n++;
    total_n++; if (sclk !== 1'b0) $display("FAIL rmid_sclk got=%b exp=0", sclk); else pass_n++;
    total_n++; if (mosi !== 1'b0) $display("FAIL rmid_mosi got=%b exp=0", mosi); else pass_n++;
    total_n++; if (busy !== 1'b0) $display("FAIL rmid_busy got=%b exp=0", busy); else pass_n++;
    repeat (3) step();
    rst = 1'b0;
    step();
    total_n++; if (rx_n != b_rx) $display("FAIL rmid_no_rx got=%0d exp=0", rx_n - b_rx); else pass_n++;
    slave_bytes[0] = 8'h7E;
    send(8'h81, 1'b1, ok);
    wait_idle(ok);
    total_n++; if (rx_n - b_rx != 1) $display("FAIL rmid_rx_pulses got=%0d exp=1", rx_n - b_rx); else pass_n++;
    total_n++; if (rx_log[b_rx[5:0]] !== 8'h7E) $display("FAIL rmid_rx got=%h exp=7e", rx_log[b_rx[5:0]]); else pass_n++;
    total_n++; if (mosi_cap[0] !== 8'h81) $display("FAIL rmid_mosi got=%h exp=81", mosi_cap[0]); else pass_n++;
  endtask

  task automatic test_back_to_back();
    logic ok;
    int acc, bad;
    int b_rx, b_rise;
    slave_bytes[0] = 8'h18;
    slave_bytes[1] = 8'h00;
    b_rx = rx_n; b_rise = ssel_rise_n;
    acc = 0; bad = 0;
    tx_data = 8'h66;
    tx_last = 1'b1;
    tx_valid = 1'b1;
    for (int i = 0; i < 1000 && acc < 2; i++) begin
      if (tx_ready === 1'b1) begin
        if (busy === 1'b1) bad++;
        acc++;
      end
      step();
    end
    tx_valid = 1'b0;
    wait_idle(ok);
    total_n++; if (acc != 2) $display("FAIL b2b_accepts got=%0d exp=2", acc); else pass_n++;
    total_n++; if (ok !== 1'b1) $display("FAIL b2b_done got=%b exp=1", ok); else pass_n++;
    total_n++; if (bad != 0) $display("FAIL b2b_ready_busy got=%0d exp=0", bad); else pass_n++;
    // GAP (CS_HOLD) cycles plus the single IDLE accept cycle
    total_n++; if (last_high_run != 3) $display("FAIL b2b_gap got=%0d exp=3", last_high_run); else pass_n++;
    total_n++; if (ssel_rise_n - b_rise != 2) $display("FAIL b2b_frames got=%0d exp=2", ssel_rise_n - b_rise); else pass_n++;
    total_n++; if (rx_n - b_rx != 2) $display("FAIL b2b_rx_pulses got=%0d exp=2", rx_n - b_rx); else pass_n++;
    total_n++; if (rx_log[6'(b_rx + 1)] !== 8'h18) $display("FAIL b2b_rx1 got=%h exp=18", rx_log[6'(b_rx + 1)]); else pass_n++;
    total_n++; if (mosi_cap[0] !== 8'h66) $display("FAIL b2b_mosi got=%h exp=66", mosi_cap[0]); else pass_n++;
  endtask

  task automatic test_bit_order();
    logic ok;
    int b_rx;
    slave_bytes[0] = 8'h80;
    slave_bytes[1] = 8'h00;
    b_rx = rx_n;
    send(8'h01, 1'b1, ok);
    wait_idle(ok);
    total_n++; if (ok !== 1'b1) $display("FAIL order_done got=%b exp=1", ok); else pass_n++;
    total_n++; if (first_mosi !== FIRST_01) $display("FAIL order_first_bit got=%b exp=%b", first_mosi, FIRST_01); else pass_n++;
    total_n++; if (rx_log[b_rx[5:0]] !== R_80) $display("FAIL order_rx got=%h exp=%h", rx_log[b_rx[5:0]], R_80); else pass_n++;
    total_n++; if (mosi_cap[0] !== W_01) $display("FAIL order_mosi got=%h exp=%h", mosi_cap[0], W_01); else pass_n++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_two_byte();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_bit_order();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
